sfp_i2c_target: RTL and testbench



---
 rtl/sfp_i2c_target.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sfp_i2c_target.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_i2c_target.sv
`timescale 1ns/1ps
// sfp_i2c_target
// I2C target that models the SFP side of the SFP management bus. It presents a
// 256x8 register space at a fixed 7-bit device address and uses a byte pointer.
// SCL/SDA are oversampled on sys_clk; there is no bus clock domain.
//
// Optional feature macro: SFP_I2C_TGT_FILTER_EN
//   defined   -> each line passes a saturating-counter glitch filter (FILTER_LEN)
//   undefined -> filtered lines are the 2-flop synchronizer outputs
//
// Ports:
//   sys_clk, rst_n           clock (>= 20x SCL), async active-low reset
//   scl_i/scl_o/scl_t        SCL pad; never driven (scl_o=0, scl_t=1)
//   sda_i/sda_o/sda_t        SDA pad; sda_o=0, sda_t=0 pulls low, 1 releases
//   host_we/addr/wdata       local write port into the register array
//   wr_valid/wr_addr/wr_data one-cycle report of a byte written by the master
//   busy                     high from an accepted START to the next STOP
module sfp_i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_PTR, WR_BYTE, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  // Line vectors: bit 0 = SCL, bit 1 = SDA.
  logic [1:0] sync1_r, sync2_r, lines_f_s;
  logic       scl_f_s, sda_f_s, scl_d_r, sda_d_r;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic       ack_phase_r;
  logic [7:0] shift_r, ptr_r, rx_byte_s;
  logic       sda_t_r, busy_r, wr_valid_r;
  logic [7:0] wr_addr_r, wr_data_r;
  logic       i2c_we_s;
  logic [7:0] mem_r [0:255];

  // Two-flop synchronizer; idle bus level is high so reset avoids false edges.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= {sda_i, scl_i};
      sync2_r <= sync1_r;
    end
  end

`ifdef SFP_I2C_TGT_FILTER_EN
  logic [1:0] filt_r;
  logic [3:0] fcnt_r [0:1];

  // Saturating counter filter: a level is accepted after FILTER_LEN equal samples.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r    <= 2'b11;
      fcnt_r[0] <= 4'd0;
      fcnt_r[1] <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          fcnt_r[i] <= 4'd0;
        end else if (fcnt_r[i] >= 4'(FILTER_LEN - 1)) begin
          filt_r[i] <= sync2_r[i];
          fcnt_r[i] <= 4'd0;
        end else begin
          fcnt_r[i] <= fcnt_r[i] + 4'd1;
        end
      end
    end
  end

  assign lines_f_s = filt_r;
`else
  assign lines_f_s = sync2_r;
`endif

  assign scl_f_s = lines_f_s[0];
  assign sda_f_s = lines_f_s[1];

  // Previous filtered levels for edge and bus-condition detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d_r <= 1'b1;
      sda_d_r <= 1'b1;
    end else begin
      scl_d_r <= scl_f_s;
      sda_d_r <= sda_f_s;
    end
  end

  assign scl_rise_s = scl_f_s & ~scl_d_r;
  assign scl_fall_s = ~scl_f_s & scl_d_r;
  // SCL must be high on both samples so an SCL edge never looks like START/STOP.
  assign start_s    = scl_f_s & scl_d_r & sda_d_r & ~sda_f_s;
  assign stop_s     = scl_f_s & scl_d_r & ~sda_d_r & sda_f_s;
  assign rx_byte_s  = {shift_r[6:0], sda_f_s};

  // The last data bit of a complete write byte commits it to the array.
  assign i2c_we_s = (state_r == WR_BYTE) && !ack_phase_r && (bit_cnt_r == 4'd7)
                    && scl_rise_s && !start_s && !stop_s;

  // Register array: I2C write wins over a host write to the same address.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_r[i] <= 8'h00;
    end else begin
      if (host_we && !(i2c_we_s && (host_addr == ptr_r))) mem_r[host_addr] <= host_wdata;
      if (i2c_we_s) mem_r[ptr_r] <= rx_byte_s;
    end
  end

  // Protocol FSM with registered SDA drive, write report and busy flag.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      ack_phase_r <= 1'b0;
      shift_r     <= 8'h00;
      ptr_r       <= 8'h00;
      sda_t_r     <= 1'b1;
      busy_r      <= 1'b0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= 8'h00;
      wr_data_r   <= 8'h00;
    end else begin
      wr_valid_r <= 1'b0;
      if (start_s) begin
        state_r     <= ADDR;
        bit_cnt_r   <= 4'd0;
        ack_phase_r <= 1'b0;
        sda_t_r     <= 1'b1;
        busy_r      <= 1'b1;
      end else if (stop_s) begin
        state_r     <= IDLE;
        bit_cnt_r   <= 4'd0;
        ack_phase_r <= 1'b0;
        sda_t_r     <= 1'b1;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          ADDR: begin
            if (scl_rise_s) begin
              shift_r <= rx_byte_s;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                state_r   <= ADDR_ACK;
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_s) begin
              if (!ack_phase_r) begin
                if (shift_r[7:1] == DEV_ADDR) begin
                  sda_t_r     <= 1'b0;
                  ack_phase_r <= 1'b1;
                end else begin
                  sda_t_r <= 1'b1;
                  state_r <= IGNORE;
                end
              end else begin
                ack_phase_r <= 1'b0;
                bit_cnt_r   <= 4'd0;
                if (shift_r[0]) begin
                  // Read byte is latched here, so later host writes cannot disturb it.
                  shift_r <= mem_r[ptr_r];
                  sda_t_r <= mem_r[ptr_r][7];
                  state_r <= RD_BYTE;
                end else begin
                  sda_t_r <= 1'b1;
                  state_r <= WR_PTR;
                end
              end
            end
          end
          WR_PTR, WR_BYTE: begin
            if (ack_phase_r) begin
              if (scl_fall_s) begin
                sda_t_r     <= 1'b1;
                ack_phase_r <= 1'b0;
                bit_cnt_r   <= 4'd0;
                state_r     <= WR_BYTE;
              end
            end else if (bit_cnt_r == 4'd8) begin
              if (scl_fall_s) begin
                sda_t_r     <= 1'b0;
                ack_phase_r <= 1'b1;
              end
            end else if (scl_rise_s) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                if (state_r == WR_PTR) begin
                  ptr_r <= rx_byte_s;
                end else begin
                  wr_valid_r <= 1'b1;
                  wr_addr_r  <= ptr_r;
                  wr_data_r  <= rx_byte_s;
                  ptr_r      <= ptr_r + 8'd1;
                end
              end
            end
          end
          RD_BYTE: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd7) begin
                sda_t_r   <= 1'b1;
                bit_cnt_r <= 4'd0;
                state_r   <= RD_ACK;
              end else begin
                sda_t_r   <= shift_r[6];
                shift_r   <= {shift_r[6:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (ack_phase_r) begin
              if (scl_fall_s) begin
                ack_phase_r <= 1'b0;
                shift_r     <= mem_r[ptr_r];
                sda_t_r     <= mem_r[ptr_r][7];
                bit_cnt_r   <= 4'd0;
                state_r     <= RD_BYTE;
              end
            end else if (scl_rise_s) begin
              ptr_r <= ptr_r + 8'd1;
              if (sda_f_s) begin
                state_r <= IGNORE;
              end else begin
                ack_phase_r <= 1'b1;
              end
            end
          end
          IGNORE:  state_r <= IGNORE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign scl_o    = 1'b0;
  assign scl_t    = 1'b1;
  assign sda_o    = 1'b0;
  assign sda_t    = sda_t_r;
  assign busy     = busy_r;
  assign wr_valid = wr_valid_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_sfp_i2c_target.sv
`timescale 1ns/1ps
// Self-checking bench for sfp_i2c_target: a bit-banged I2C master drives the
// pads on clock negedges; expected write reports and read bytes sit in queues.
module tb_sfp_i2c_target;
  localparam int T = 10;  // sys_clk period
  localparam int Q = 8;   // quarter SCL period in sys_clk cycles

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'h00;
  logic [7:0] host_wdata = 8'h00;
  logic       scl_o, scl_t, sda_o, sda_t, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  logic       scl_line, sda_line;

  int n_checks = 0;
  int n_errors = 0;
  int wr_pushed = 0;
  int wr_seen = 0;
  int sda_low_total = 0;
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];

  assign scl_line = scl_m & (scl_t | scl_o);
  assign sda_line = sda_m & (sda_t | sda_o);

  sfp_i2c_target #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .scl_i(scl_line), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_line), .sda_o(sda_o), .sda_t(sda_t),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #(T/2) sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-report scoreboard and SDA-pull-low counter.
  always @(negedge sys_clk) begin
    if (!sda_t) sda_low_total <= sda_low_total + 1;
    if (wr_valid) begin
      wr_seen <= wr_seen + 1;
      if (wr_q.size() != 0) begin
        logic [15:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[15:8]});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    wr_pushed++;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    cyc(1);
    host_we = 1'b0;
  endtask

  task automatic start_cond();
    cyc(Q); sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q); sda_m = 1'b0; cyc(Q); scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    cyc(Q); sda_m = 1'b0; cyc(Q); scl_m = 1'b1; cyc(Q); sda_m = 1'b1; cyc(Q);
  endtask

  // Send the top nbits of b; bit index 'glitch' gets a 2-cycle SCL low pulse.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int glitch);
    for (int i = 7; i > 7 - nbits; i--) begin
      cyc(Q); sda_m = b[i]; cyc(Q); scl_m = 1'b1;
      if (i == glitch) begin
        cyc(3); scl_m = 1'b0; cyc(2); scl_m = 1'b1; cyc(3);
      end else begin
        cyc(Q);
      end
      cyc(Q); scl_m = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch, output logic ack);
    send_bits(b, 8, glitch);
    cyc(Q); sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q); ack = sda_line; cyc(Q); scl_m = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic nack);
    logic [7:0] b;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      cyc(Q); sda_m = 1'b1; cyc(Q); scl_m = 1'b1; cyc(Q); b[i] = sda_line; cyc(Q); scl_m = 1'b0;
    end
    cyc(Q); sda_m = nack; cyc(Q); scl_m = 1'b1; cyc(2*Q); scl_m = 1'b0;
    e = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
    chk(tag, {24'd0, b}, {24'd0, e});
  endtask

  logic ack;
  int   low0;
  logic [7:0] glitch_exp;
  logic       glitch_ack_exp;

  initial begin
`ifdef SFP_I2C_TGT_FILTER_EN
    glitch_exp = 8'hA5; glitch_ack_exp = 1'b0;
`else
    glitch_exp = 8'hA2; glitch_ack_exp = 1'b1;  // bit 4 sampled twice, bit 0 lost
`endif
    // Reset values
    cyc(3);
    chk("rst_sda_t", {31'd0, sda_t}, 32'd1);
    chk("rst_scl_t", {31'd0, scl_t}, 32'd1);
    chk("rst_oe_lvl", {30'd0, sda_o, scl_o}, 32'd0);
    chk("rst_wr", {15'd0, wr_valid, wr_addr, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ptr", {24'd0, dut.ptr_r}, 32'd0);
    rst_n = 1'b1;
    cyc(4);

    // Basic write: ptr=10, A5, 3C
    start_cond();
    chk("busy_start", {31'd0, busy}, 32'd1);
    send_byte(8'hA0, -1, ack); chk("t1_ack_addr", {31'd0, ack}, 32'd0);
    send_byte(8'h10, -1, ack); chk("t1_ack_ptr", {31'd0, ack}, 32'd0);
    push_wr(8'h10, 8'hA5);
    send_byte(8'hA5, -1, ack); chk("t1_ack_d0", {31'd0, ack}, 32'd0);
    push_wr(8'h11, 8'h3C);
    send_byte(8'h3C, -1, ack); chk("t1_ack_d1", {31'd0, ack}, 32'd0);
    stop_cond();
    chk("t1_mem10", {24'd0, dut.mem_r[8'h10]}, 32'hA5);
    chk("t1_mem11", {24'd0, dut.mem_r[8'h11]}, 32'h3C);
    chk("t1_ptr", {24'd0, dut.ptr_r}, 32'h12);
    chk("busy_stop", {31'd0, busy}, 32'd0);

    // Read with repeated START
    host_wr(8'h20, 8'h01); host_wr(8'h21, 8'h02); host_wr(8'h22, 8'h03);
    start_cond();
    send_byte(8'hA0, -1, ack); chk("t2_ack_addr", {31'd0, ack}, 32'd0);
    send_byte(8'h20, -1, ack); chk("t2_ack_ptr", {31'd0, ack}, 32'd0);
    start_cond();
    send_byte(8'hA1, -1, ack); chk("t2_ack_raddr", {31'd0, ack}, 32'd0);
    rd_q.push_back(8'h01); rd_q.push_back(8'h02); rd_q.push_back(8'h03);
    recv_byte("t2_rd0", 1'b0);
    recv_byte("t2_rd1", 1'b0);
    recv_byte("t2_rd2", 1'b1);
    stop_cond();
    chk("t2_ptr", {24'd0, dut.ptr_r}, 32'h23);

    // Foreign address 51h
    low0 = sda_low_total;
    start_cond();
    send_byte(8'hA2, -1, ack); chk("t3_nack_addr", {31'd0, ack}, 32'd1);
    send_byte(8'h55, -1, ack); chk("t3_nack_data", {31'd0, ack}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    stop_cond();
    chk("t3_sda_low", 32'(sda_low_total - low0), 32'd0);
    chk("t3_busy_end", {31'd0, busy}, 32'd0);
    chk("t3_ptr", {24'd0, dut.ptr_r}, 32'h23);

    // Pointer wrap
    start_cond();
    send_byte(8'hA0, -1, ack); send_byte(8'hFE, -1, ack);
    push_wr(8'hFE, 8'h11); send_byte(8'h11, -1, ack);
    push_wr(8'hFF, 8'h22); send_byte(8'h22, -1, ack);
    push_wr(8'h00, 8'h33); send_byte(8'h33, -1, ack);
    chk("t4_ack", {31'd0, ack}, 32'd0);
    stop_cond();
    chk("t4_memFE", {24'd0, dut.mem_r[8'hFE]}, 32'h11);
    chk("t4_memFF", {24'd0, dut.mem_r[8'hFF]}, 32'h22);
    chk("t4_mem00", {24'd0, dut.mem_r[8'h00]}, 32'h33);
    chk("t4_ptr", {24'd0, dut.ptr_r}, 32'h01);

    // STOP after 5 bits of a data byte
    host_wr(8'h40, 8'h77);
    start_cond();
    send_byte(8'hA0, -1, ack); send_byte(8'h40, -1, ack);
    send_bits(8'hC3, 5, -1);
    stop_cond();
    chk("t5_mem40", {24'd0, dut.mem_r[8'h40]}, 32'h77);
    chk("t5_ptr", {24'd0, dut.ptr_r}, 32'h40);
    chk("t5_sda_t", {31'd0, sda_t}, 32'd1);

    // Reset during ACK
    start_cond();
    send_byte(8'hA0, -1, ack); send_byte(8'h41, -1, ack);
    push_wr(8'h41, 8'h99);
    send_bits(8'h99, 8, -1);
    cyc(Q);
    chk("t5_ack_drv", {31'd0, sda_t}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sda", {31'd0, sda_t}, 32'd1);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(4);
    chk("t5_rst_ptr", {24'd0, dut.ptr_r}, 32'd0);
    chk("t5_rst_mem41", {24'd0, dut.mem_r[8'h41]}, 32'd0);
    rst_n = 1'b1;
    cyc(4);
    start_cond();
    send_byte(8'hA0, -1, ack); chk("t5_next_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h05, -1, ack);
    push_wr(8'h05, 8'h5A);
    send_byte(8'h5A, -1, ack);
    stop_cond();
    chk("t5_next_mem", {24'd0, dut.mem_r[8'h05]}, 32'h5A);
    chk("t5_next_ptr", {24'd0, dut.ptr_r}, 32'h06);

    // SCL glitch during data bit 4
    start_cond();
    send_byte(8'hA0, -1, ack); send_byte(8'h60, -1, ack);
    push_wr(8'h60, glitch_exp);
    send_byte(8'hA5, 4, ack);
    chk("t6_ack", {31'd0, ack}, {31'd0, glitch_ack_exp});
    stop_cond();
    chk("t6_mem60", {24'd0, dut.mem_r[8'h60]}, {24'd0, glitch_exp});
    chk("t6_ptr", {24'd0, dut.ptr_r}, 32'h61);

    cyc(4);
    chk("wr_count", 32'(wr_seen), 32'(wr_pushed));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
